mem_port_arbiter: RTL and testbench

//  Shares the single four-banked data memory between two cache controllers (port 0 = I-cache, port 1 = D-cache).

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one banked data memory between the I-cache (port 0)
// and D-cache (port 1); grants whole locked bursts and routes read data back by owner tag.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_read,
    input  logic              r0_write,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_stall,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_read,
    input  logic              r1_write,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_stall,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_winner_q, last_winner_d;
    logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LATENCY-1:0] rd_own_q, rd_own_d;
    logic [1:0]            wr_ack_q, wr_ack_d;

    logic req0, req1;
    logic own, own_req, own_read, own_write, own_lock, oth_req;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic acc_rd, acc_wr;
    logic rd_done, rd_owner;

    // Read and write together is treated as no request at all.
    assign req0 = r0_read ^ r0_write;
    assign req1 = r1_read ^ r1_write;

    // Owner-side view of the two ports; only meaningful in OWN0/OWN1.
    always_comb begin
        own       = (state_q == OWN1);
        own_req   = own ? req1     : req0;
        own_read  = own ? r1_read  : r0_read;
        own_write = own ? r1_write : r0_write;
        own_lock  = own ? r1_lock  : r0_lock;
        own_addr  = own ? r1_addr  : r0_addr;
        own_wdata = own ? r1_wdata : r0_wdata;
        oth_req   = own ? req0     : req1;
    end

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        r0_stall      = req0;
        r1_stall      = req1;
        acc_rd        = 1'b0;
        acc_wr        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d       = last_winner_q ? OWN0 : OWN1;
                    last_winner_d = ~last_winner_q;
                end else if (req0) begin
                    state_d       = OWN0;
                    last_winner_d = 1'b0;
                end else if (req1) begin
                    state_d       = OWN1;
                    last_winner_d = 1'b1;
                end
            end
            OWN0, OWN1: begin
                mem_read  = own_req & own_read;
                mem_write = own_req & own_write;
                mem_addr  = own_addr;
                mem_wdata = own_wdata;
                acc_rd    = own_req & own_read  & ~mem_stall;
                acc_wr    = own_req & own_write & ~mem_stall;
                if (own) r1_stall = req1 & mem_stall;
                else     r0_stall = req0 & mem_stall;
                // Grant is only given up once the owner has neither a request nor a lock.
                if (!own_req && !own_lock) begin
                    if (oth_req) begin
                        state_d       = own ? OWN0 : OWN1;
                        last_winner_d = ~own;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read tag pipe: stage i holds accepts from i+1 cycles ago.
    always_comb begin
        rd_vld_d    = '0;
        rd_own_d    = '0;
        rd_vld_d[0] = acc_rd;
        rd_own_d[0] = own;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_own_d[i] = rd_own_q[i-1];
        end
        wr_ack_d = {acc_wr & own, acc_wr & ~own};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_winner_q <= 1'b1;
            rd_vld_q      <= '0;
            rd_own_q      <= '0;
            wr_ack_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            rd_vld_q      <= rd_vld_d;
            rd_own_q      <= rd_own_d;
            wr_ack_q      <= wr_ack_d;
        end
    end

    assign rd_done  = rd_vld_q[RD_LATENCY-1];
    assign rd_owner = rd_own_q[RD_LATENCY-1];

    always_comb begin
        r0_done  = wr_ack_q[0] | (rd_done & ~rd_owner);
        r1_done  = wr_ack_q[1] | (rd_done &  rd_owner);
        r0_rdata = (rd_done & ~rd_owner) ? mem_rdata : '0;
        r1_rdata = (rd_done &  rd_owner) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model
// of the two-port memory arbiter.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst;
    logic r0_read, r0_write, r0_lock, r1_read, r1_write, r1_lock;
    logic [AW-1:0] r0_addr, r1_addr, mem_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, mem_wdata, mem_rdata, r0_rdata, r1_rdata;
    logic r0_stall, r0_done, r1_stall, r1_done, mem_read, mem_write, mem_stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .r0_read(r0_read), .r0_write(r0_write), .r0_lock(r0_lock),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_stall(r0_stall), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_read(r1_read), .r1_write(r1_write), .r1_lock(r1_lock),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_stall(r1_stall), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_read = 0; r0_write = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
        r1_read = 0; r1_write = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
        mem_rdata = '0; mem_stall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if ({r0_done, r1_done, r0_stall, r1_stall, mem_read, mem_write} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 000000", {r0_done, r1_done, r0_stall, r1_stall, mem_read, mem_write}); end
        n_cmp++; if ({mem_addr, mem_wdata, r0_rdata, r1_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, r0_rdata, r1_rdata}); end
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        r0_read = 1; r0_addr = 16'h0010;
        @(negedge clk);
        n_cmp++; if (r0_stall !== 1'b1 || mem_read !== 1'b0) begin
            n_err++; $display("FAIL single_c0 stall=%b mem_read=%b want 1 0", r0_stall, mem_read); end
        tick();
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 16'h0010 || r0_stall !== 1'b0) begin
            n_err++; $display("FAIL single_c1 mem_read=%b addr=%h stall=%b want 1 0010 0", mem_read, mem_addr, r0_stall); end
        tick();
        r0_read = 0;
        @(negedge clk);
        n_cmp++; if (r0_done !== 1'b0) begin n_err++; $display("FAIL single_c2 done=%b want 0", r0_done); end
        tick();
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        n_cmp++; if (r0_done !== 1'b1 || r0_rdata !== 16'hBEEF || r1_done !== 1'b0) begin
            n_err++; $display("FAIL single_c3 done=%b rdata=%h r1_done=%b want 1 beef 0", r0_done, r0_rdata, r1_done); end
        tick();
        mem_rdata = '0;
        @(negedge clk);
        n_cmp++; if (r0_done !== 1'b0) begin n_err++; $display("FAIL single_c4 done=%b want 0", r0_done); end
        tick();
    endtask

    task automatic test_tie();
        do_reset();
        r0_write = 1; r0_addr = 16'h0100; r0_wdata = 16'h1111;
        r1_write = 1; r1_addr = 16'h0200; r1_wdata = 16'h2222;
        @(negedge clk);
        n_cmp++; if ({r0_stall, r1_stall, mem_write} !== 3'b110) begin
            n_err++; $display("FAIL tie_c0 got %b want 110", {r0_stall, r1_stall, mem_write}); end
        tick();
        @(negedge clk);
        n_cmp++; if (mem_write !== 1 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1111 || {r0_stall, r1_stall} !== 2'b01) begin
            n_err++; $display("FAIL tie_first got w=%b a=%h d=%h st=%b%b want port0", mem_write, mem_addr, mem_wdata, r0_stall, r1_stall); end
        tick();
        r0_write = 0; r1_write = 0;
        @(negedge clk);
        n_cmp++; if (r0_done !== 1'b1 || r0_rdata !== '0) begin
            n_err++; $display("FAIL tie_wdone got %b %h want 1 0", r0_done, r0_rdata); end
        tick();
        r0_write = 1; r1_write = 1;
        @(negedge clk);
        n_cmp++; if ({r0_stall, r1_stall, mem_write} !== 3'b110) begin
            n_err++; $display("FAIL tie_idle2 got %b want 110", {r0_stall, r1_stall, mem_write}); end
        tick();
        @(negedge clk);
        n_cmp++; if (mem_write !== 1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h2222 || {r0_stall, r1_stall} !== 2'b10) begin
            n_err++; $display("FAIL tie_second got w=%b a=%h d=%h st=%b%b want port1", mem_write, mem_addr, mem_wdata, r0_stall, r1_stall); end
        tick();
        r1_write = 0;
        @(negedge clk);
        n_cmp++; if (r1_done !== 1'b1 || r0_stall !== 1'b1) begin
            n_err++; $display("FAIL tie_r1done got done=%b stall0=%b want 1 1", r1_done, r0_stall); end
        tick();
        @(negedge clk);
        n_cmp++; if (mem_addr !== 16'h0100 || r0_stall !== 1'b0 || mem_write !== 1'b1) begin
            n_err++; $display("FAIL tie_back0 got a=%h st=%b w=%b want 0100 0 1", mem_addr, r0_stall, mem_write); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_locked_burst();
        do_reset();
        r1_read = 1; r1_lock = 1; r1_addr = 16'h0020;
        @(negedge clk);
        n_cmp++; if (r1_stall !== 1'b1) begin n_err++; $display("FAIL burst_c0 stall1=%b want 1", r1_stall); end
        tick();
        for (int i = 0; i < 4; i++) begin
            r1_addr = 16'h0020 + 16'(2 * i);
            r0_read = 1; r0_addr = 16'h0300;
            mem_rdata = 16'hA000 + 16'(i);
            @(negedge clk);
            n_cmp++; if (mem_read !== 1 || mem_addr !== 16'h0020 + 16'(2 * i) || {r1_stall, r0_stall} !== 2'b01) begin
                n_err++; $display("FAIL burst_acc%0d got r=%b a=%h st1=%b st0=%b", i, mem_read, mem_addr, r1_stall, r0_stall); end
            if (i >= 2) begin
                n_cmp++; if (r1_done !== 1'b1 || r1_rdata !== 16'hA000 + 16'(i)) begin
                    n_err++; $display("FAIL burst_done%0d got %b %h want 1 %h", i, r1_done, r1_rdata, 16'hA000 + 16'(i)); end
            end
            tick();
        end
        r1_read = 0; mem_rdata = 16'hA005;
        @(negedge clk);
        n_cmp++; if (r0_stall !== 1 || mem_read !== 0 || r1_done !== 1 || r1_rdata !== 16'hA005) begin
            n_err++; $display("FAIL burst_lockhold got st0=%b r=%b d=%b %h", r0_stall, mem_read, r1_done, r1_rdata); end
        tick();
        r1_lock = 0; mem_rdata = 16'hA006;
        @(negedge clk);
        n_cmp++; if (r0_stall !== 1 || mem_read !== 0 || r1_done !== 1 || r1_rdata !== 16'hA006) begin
            n_err++; $display("FAIL burst_release got st0=%b r=%b d=%b %h", r0_stall, mem_read, r1_done, r1_rdata); end
        tick();
        @(negedge clk);
        n_cmp++; if (mem_read !== 1 || mem_addr !== 16'h0300 || r0_stall !== 0 || r1_done !== 0) begin
            n_err++; $display("FAIL burst_handoff got r=%b a=%h st0=%b d1=%b", mem_read, mem_addr, r0_stall, r1_done); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_mem_stall();
        do_reset();
        r0_write = 1; r0_addr = 16'h0040; r0_wdata = 16'h5A5A;
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_stall = 1;
            @(negedge clk);
            n_cmp++; if ({mem_write, r0_stall, r0_done} !== 3'b110 || mem_wdata !== 16'h5A5A) begin
                n_err++; $display("FAIL mstall_c%0d got w/st/d=%b data=%h want 110 5a5a", i, {mem_write, r0_stall, r0_done}, mem_wdata); end
            tick();
        end
        mem_stall = 0;
        @(negedge clk);
        n_cmp++; if ({mem_write, r0_stall, r0_done} !== 3'b100) begin
            n_err++; $display("FAIL mstall_accept got %b want 100", {mem_write, r0_stall, r0_done}); end
        tick();
        r0_write = 0;
        @(negedge clk);
        n_cmp++; if (r0_done !== 1'b1 || r0_rdata !== '0) begin
            n_err++; $display("FAIL mstall_done got %b %h want 1 0", r0_done, r0_rdata); end
        tick();
        @(negedge clk);
        n_cmp++; if (r0_done !== 1'b0) begin n_err++; $display("FAIL mstall_once got %b want 0", r0_done); end
        tick();
    endtask

    task automatic test_switch_inflight();
        do_reset();
        r1_read = 1; r1_addr = 16'h0050;
        tick();
        @(negedge clk);
        n_cmp++; if (mem_read !== 1 || mem_addr !== 16'h0050 || r1_stall !== 0) begin
            n_err++; $display("FAIL switch_acc got r=%b a=%h st=%b", mem_read, mem_addr, r1_stall); end
        tick();
        r1_read = 0; r0_read = 1; r0_addr = 16'h0060;
        tick();
        mem_rdata = 16'hC0DE;
        @(negedge clk);
        n_cmp++; if (mem_read !== 1 || mem_addr !== 16'h0060 || r1_done !== 1 || r1_rdata !== 16'hC0DE || r0_done !== 0 || r0_rdata !== '0) begin
            n_err++; $display("FAIL switch_route got a=%h d1=%b rd1=%h d0=%b rd0=%h", mem_addr, r1_done, r1_rdata, r0_done, r0_rdata); end
        tick();
        r0_read = 0; mem_rdata = 16'hD00D;
        @(negedge clk);
        n_cmp++; if (r0_done !== 0 || r1_done !== 0) begin
            n_err++; $display("FAIL switch_gap got d0=%b d1=%b want 0 0", r0_done, r1_done); end
        tick();
        mem_rdata = 16'h1234;
        @(negedge clk);
        n_cmp++; if (r0_done !== 1 || r0_rdata !== 16'h1234 || r1_done !== 0) begin
            n_err++; $display("FAIL switch_r0done got %b %h d1=%b want 1 1234 0", r0_done, r0_rdata, r1_done); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        r0_read = 1; r0_addr = 16'h0070;
        tick();
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rstmid_acc got %b want 1", mem_read); end
        tick();
        rst = 1; r0_read = 0;
        tick();
        rst = 0; mem_rdata = 16'hFFFF;
        @(negedge clk);
        n_cmp++; if ({r0_done, r1_done, mem_read, r0_stall} !== 4'b0 || r0_rdata !== '0) begin
            n_err++; $display("FAIL rstmid_nodone got %b rd=%h want 0000 0", {r0_done, r1_done, mem_read, r0_stall}, r0_rdata); end
        tick();
        r0_write = 1; r0_addr = 16'h0080; mem_rdata = '0;
        @(negedge clk);
        n_cmp++; if (r0_done !== 0 || r0_stall !== 1) begin
            n_err++; $display("FAIL rstmid_idle got d=%b st=%b want 0 1", r0_done, r0_stall); end
        tick();
        @(negedge clk);
        n_cmp++; if (mem_write !== 1 || mem_addr !== 16'h0080 || r0_stall !== 0) begin
            n_err++; $display("FAIL rstmid_regrant got w=%b a=%h st=%b", mem_write, mem_addr, r0_stall); end
        tick();
        r0_write = 0;
        @(negedge clk);
        n_cmp++; if (r0_done !== 1'b1) begin n_err++; $display("FAIL rstmid_wdone got %b want 1", r0_done); end
        tick();
    endtask

    // Transaction-level model: owner id, round-robin pointer, and scheduled completions by cycle.
    task automatic test_random();
        int owner;
        bit last;
        int cyc;
        int wq_cyc[$], wq_own[$], rq_cyc[$], rq_own[$];
        bit rd[2], wr[2], lk[2], req[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2];
        bit e_mr, e_mw, e_st[2], e_d[2];
        logic [AW-1:0] e_ma;
        logic [DW-1:0] e_md, e_rd[2];
        bit do_rst;
        do_reset();
        owner = -1; last = 1; cyc = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int p = 0; p < 2; p++) begin
                int op;
                op = int'($urandom_range(0, 19));
                rd[p] = (op >= 6 && op < 12) || op == 19;
                wr[p] = (op >= 12);
                lk[p] = ($urandom_range(0, 3) == 0);
                ad[p] = AW'($urandom);
                wd[p] = DW'($urandom);
            end
            do_rst = ($urandom_range(0, 99) == 0);
            rst = do_rst;
            r0_read = rd[0]; r0_write = wr[0]; r0_lock = lk[0]; r0_addr = ad[0]; r0_wdata = wd[0];
            r1_read = rd[1]; r1_write = wr[1]; r1_lock = lk[1]; r1_addr = ad[1]; r1_wdata = wd[1];
            mem_stall = ($urandom_range(0, 3) == 0);
            mem_rdata = DW'($urandom);
            for (int p = 0; p < 2; p++) req[p] = rd[p] ^ wr[p];

            e_mr = 0; e_mw = 0; e_ma = '0; e_md = '0;
            e_st[0] = req[0]; e_st[1] = req[1];
            if (owner >= 0) begin
                e_mr = req[owner] && rd[owner];
                e_mw = req[owner] && wr[owner];
                e_ma = ad[owner];
                e_md = wd[owner];
                e_st[owner] = req[owner] && mem_stall;
            end
            e_d[0] = 0; e_d[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
            while (wq_cyc.size() > 0 && wq_cyc[0] == cyc) begin
                e_d[wq_own[0]] = 1; void'(wq_cyc.pop_front()); void'(wq_own.pop_front());
            end
            while (rq_cyc.size() > 0 && rq_cyc[0] == cyc) begin
                e_d[rq_own[0]] = 1; e_rd[rq_own[0]] = mem_rdata;
                void'(rq_cyc.pop_front()); void'(rq_own.pop_front());
            end

            @(negedge clk);
            n_cmp++; if ({mem_read, mem_write, r0_stall, r1_stall} !== {e_mr, e_mw, e_st[0], e_st[1]}) begin
                n_err++; $display("FAIL rnd_ctrl cyc=%0d got r/w/st0/st1=%b want %b", cyc, {mem_read, mem_write, r0_stall, r1_stall}, {e_mr, e_mw, e_st[0], e_st[1]}); end
            n_cmp++; if (mem_addr !== e_ma || mem_wdata !== e_md) begin
                n_err++; $display("FAIL rnd_mem cyc=%0d got a=%h d=%h want a=%h d=%h", cyc, mem_addr, mem_wdata, e_ma, e_md); end
            n_cmp++; if (r0_done !== e_d[0] || r1_done !== e_d[1]) begin
                n_err++; $display("FAIL rnd_done cyc=%0d got %b%b want %b%b", cyc, r0_done, r1_done, e_d[0], e_d[1]); end
            n_cmp++; if (r0_rdata !== e_rd[0] || r1_rdata !== e_rd[1]) begin
                n_err++; $display("FAIL rnd_rdata cyc=%0d got %h %h want %h %h", cyc, r0_rdata, r1_rdata, e_rd[0], e_rd[1]); end

            if (owner >= 0 && req[owner] && !mem_stall) begin
                if (wr[owner]) begin wq_cyc.push_back(cyc + 1); wq_own.push_back(owner); end
                else begin rq_cyc.push_back(cyc + L); rq_own.push_back(owner); end
            end
            if (owner < 0) begin
                if (req[0] && req[1]) owner = last ? 0 : 1;
                else if (req[0]) owner = 0;
                else if (req[1]) owner = 1;
                if (owner >= 0) last = owner[0];
            end else if (!req[owner] && !lk[owner]) begin
                if (req[1 - owner]) begin owner = 1 - owner; last = owner[0]; end
                else owner = -1;
            end
            if (do_rst) begin
                owner = -1; last = 1;
                wq_cyc.delete(); wq_own.delete(); rq_cyc.delete(); rq_own.delete();
            end
            cyc++;
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_locked_burst();
        test_mem_stall();
        test_switch_inflight();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
